// File: rtl/wb_stream_pkg.sv
// Shared register map, status bit positions and count-width helper for the
// Wishbone-to-stream FIFO bridge.
package wb_stream_pkg;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;

    localparam int TXOVF_BIT = 31;
    localparam int RXUNF_BIT = 30;
    localparam int RXOVF_BIT = 29;
    localparam int RXCNT_LSB = 16;

    // Occupancy counters need one extra bit so that "full" (DEPTH) is representable.
    function automatic int cnt_w(input int dbits);
        return dbits + 1;
    endfunction

endpackage

// File: rtl/wb_stream_fifo_sync_fifo.sv
// Single-clock FIFO with flop storage. The head word is read straight out of
// the storage flops, so there is no combinational path from din to dout.
// Push on full and pop on empty are ignored; push+pop together keep the count.
module sync_fifo
    import wb_stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DBITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [WIDTH-1:0]          din,
    input  logic                      pop,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic [cnt_w(DBITS)-1:0]   count
);

    localparam int DEPTH = 1 << DBITS;
    localparam int CW    = cnt_w(DBITS);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DBITS-1:0] wr_ptr;
    logic [DBITS-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array: written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally mod DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_stream_fifo.sv
// Wishbone-style responder bridging bus DATA/STATUS registers to a TX and an
// RX valid/ready stream. Every cyc&stb cycle is acked exactly one cycle later.
module wb_stream_fifo
    import wb_stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DBITS = 4,
    parameter int ABITS = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic             bst_i,
    input  logic [ABITS-1:0] adr_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic             ack_o,
    output logic [WIDTH-1:0] dat_o,
    output logic             tx_valid_o,
    output logic [WIDTH-1:0] tx_data_o,
    input  logic             tx_ready_i,
    input  logic             rx_valid_i,
    input  logic [WIDTH-1:0] rx_data_i,
    output logic             rx_ready_o,
    output logic             irq_o
);

    localparam int CW = cnt_w(DBITS);

    logic             acc_p0;
    logic             sel_data_p0;
    logic             sel_stat_p0;
    logic             wr_data_p0;
    logic             rd_data_p0;
    logic             wr_stat_p0;
    logic             unused_p0;
    logic [WIDTH-1:0] status_p0;
    logic [WIDTH-1:0] rdata_p0;

    logic             ack_p1;
    logic [WIDTH-1:0] dat_p1;

    logic             tx_push;
    logic             tx_pop;
    logic             tx_full;
    logic             tx_empty;
    logic [CW-1:0]    tx_count;

    logic             rx_push;
    logic             rx_pop;
    logic             rx_full;
    logic             rx_empty;
    logic [CW-1:0]    rx_count;
    logic [WIDTH-1:0] rx_head;

    logic             txovf;
    logic             rxunf;
    logic             txovf_set;
    logic             rxunf_set;
    logic             txovf_clr;
    logic             rxunf_clr;
    logic             run;

    // Burst hint carries no address meaning here; upper address bits are not decoded.
    assign unused_p0 = bst_i ^ (^adr_i);

    assign acc_p0      = cyc_i && stb_i;
    assign sel_data_p0 = (adr_i[1:0] == ADR_DATA);
    assign sel_stat_p0 = (adr_i[1:0] == ADR_STATUS);
    assign wr_data_p0  = acc_p0 && we_i && sel_data_p0;
    assign rd_data_p0  = acc_p0 && !we_i && sel_data_p0;
    assign wr_stat_p0  = acc_p0 && we_i && sel_stat_p0;

    // A full TX FIFO drops the word (no pass-through even if it drains this cycle).
    assign tx_push    = wr_data_p0 && !tx_full;
    assign tx_pop     = tx_valid_o && tx_ready_i;
    assign tx_valid_o = !tx_empty;

    // rx_ready_o is held low until the first clock after reset release.
    assign rx_ready_o = run && !rx_full;
    assign rx_push    = rx_valid_i && rx_ready_o;
    assign rx_pop     = rd_data_p0 && !rx_empty;

    assign txovf_set = wr_data_p0 && tx_full;
    assign rxunf_set = rd_data_p0 && rx_empty;
    assign txovf_clr = wr_stat_p0 && dat_i[TXOVF_BIT];
    assign rxunf_clr = wr_stat_p0 && dat_i[RXUNF_BIT];

    assign irq_o = !rx_empty || txovf || rxunf;
    assign ack_o = ack_p1;
    assign dat_o = dat_p1;

    sync_fifo #(.WIDTH(WIDTH), .DBITS(DBITS)) u_tx_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (tx_push),
        .din   (dat_i),
        .pop   (tx_pop),
        .dout  (tx_data_o),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(WIDTH), .DBITS(DBITS)) u_rx_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (rx_push),
        .din   (rx_data_i),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // STATUS image built from pre-update counts and flags.
    always_comb begin
        status_p0                       = '0;
        status_p0[TXOVF_BIT]            = txovf;
        status_p0[RXUNF_BIT]            = rxunf;
        status_p0[RXOVF_BIT]            = 1'b0;
        status_p0[RXCNT_LSB +: CW]      = rx_count;
        status_p0[CW-1:0]               = tx_count;
    end

    // Read-data select; empty DATA reads and unmapped offsets return zero.
    always_comb begin
        rdata_p0 = '0;
        if (sel_data_p0) begin
            rdata_p0 = rx_empty ? '0 : rx_head;
        end else if (sel_stat_p0) begin
            rdata_p0 = status_p0;
        end
    end

    // ---- stage p0 -> p1: registered ack and read data ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_p1 <= 1'b0;
            dat_p1 <= '0;
        end else begin
            ack_p1 <= acc_p0;
            dat_p1 <= (acc_p0 && !we_i) ? rdata_p0 : '0;
        end
    end

    // Sticky error flags: a new event in the same cycle beats the W1C clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            txovf <= 1'b0;
            rxunf <= 1'b0;
        end else begin
            txovf <= txovf_set || (txovf && !txovf_clr);
            rxunf <= rxunf_set || (rxunf && !rxunf_clr);
        end
    end

    // Run flag gating rx_ready_o out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

endmodule
